// File: rtl/complex_alu_scheduler_pkg.sv
// Shared encodings, widths and sign-extension helpers for the complex ALU scheduler.
package complex_alu_scheduler_pkg;

  localparam int PART_W  = 5;
  localparam int OPND_W  = 10;
  localparam int FIELD_W = 11;
  localparam int RES_W   = 22;

  typedef enum logic [1:0] {
    SEL_ADD     = 2'b00,
    SEL_SUB     = 2'b01,
    SEL_MUL     = 2'b10,
    SEL_MUL_ALT = 2'b11
  } alu_sel_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic logic [FIELD_W-1:0] sext_part(input logic [PART_W-1:0] v);
    return {{(FIELD_W-PART_W){v[PART_W-1]}}, v};
  endfunction

  function automatic logic [FIELD_W-1:0] sext_prod(input logic [OPND_W-1:0] v);
    return {{(FIELD_W-OPND_W){v[OPND_W-1]}}, v};
  endfunction

endpackage

// File: rtl/complex_alu_scheduler_if.sv
// Requester, response and counter signals of the complex ALU scheduler.
interface complex_alu_scheduler_if
  import complex_alu_scheduler_pkg::*;
#(
  parameter int OVF_CNT_W = 8
);
  logic                 req0_valid;
  logic                 req0_ready;
  logic [OPND_W-1:0]    req0_op_a;
  logic [OPND_W-1:0]    req0_op_b;
  logic [1:0]           req0_sel;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [OPND_W-1:0]    req1_op_a;
  logic [OPND_W-1:0]    req1_op_b;
  logic [1:0]           req1_sel;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [RES_W-1:0]     rsp_result;
  logic                 rsp_ovf_real;
  logic                 rsp_ovf_imag;
  logic                 rsp_id;
  logic [OVF_CNT_W-1:0] ovf_count;
  logic                 clr_count;

  modport slave (
    input  req0_valid, req0_op_a, req0_op_b, req0_sel,
    input  req1_valid, req1_op_a, req1_op_b, req1_sel,
    input  rsp_ready, clr_count,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_result, rsp_ovf_real, rsp_ovf_imag, rsp_id,
    output ovf_count
  );

  modport master (
    output req0_valid, req0_op_a, req0_op_b, req0_sel,
    output req1_valid, req1_op_a, req1_op_b, req1_sel,
    output rsp_ready, clr_count,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_result, rsp_ovf_real, rsp_ovf_imag, rsp_id,
    input  ovf_count
  );

endinterface

// File: rtl/complex_alu_scheduler_alu.sv
// Combinational complex ALU: add, subtract or multiply two packed 5+5-bit complex operands.
module complex_alu_scheduler_alu
  import complex_alu_scheduler_pkg::*;
(
  input  logic [OPND_W-1:0] op_a,
  input  logic [OPND_W-1:0] op_b,
  input  logic [1:0]        sel,
  output logic [RES_W-1:0]  result,
  output logic              ovf_real,
  output logic              ovf_imag
);

  logic [PART_W-1:0]  ar, ai, br, bi;
  logic [OPND_W-1:0]  ar_x, ai_x, br_x, bi_x;
  logic [OPND_W-1:0]  p_rr, p_ii, p_ri, p_ir;
  logic [FIELD_W-1:0] re, im;

  assign ar = op_a[OPND_W-1:PART_W];
  assign ai = op_a[PART_W-1:0];
  assign br = op_b[OPND_W-1:PART_W];
  assign bi = op_b[PART_W-1:0];

  assign ar_x = {{(OPND_W-PART_W){ar[PART_W-1]}}, ar};
  assign ai_x = {{(OPND_W-PART_W){ai[PART_W-1]}}, ai};
  assign br_x = {{(OPND_W-PART_W){br[PART_W-1]}}, br};
  assign bi_x = {{(OPND_W-PART_W){bi[PART_W-1]}}, bi};

  // Low 10 bits of an unsigned product of sign-extended operands equal the signed product.
  assign p_rr = ar_x * br_x;
  assign p_ii = ai_x * bi_x;
  assign p_ri = ar_x * bi_x;
  assign p_ir = ai_x * br_x;

  // Each field holds the exact part result, so its upper bits are the sign or, on overflow, the carry-out.
  always_comb begin
    re       = {FIELD_W{1'b0}};
    im       = {FIELD_W{1'b0}};
    ovf_real = 1'b0;
    ovf_imag = 1'b0;
    case (alu_sel_e'(sel))
      SEL_ADD: begin
        re       = sext_part(ar) + sext_part(br);
        im       = sext_part(ai) + sext_part(bi);
        ovf_real = re[PART_W] ^ re[PART_W-1];
        ovf_imag = im[PART_W] ^ im[PART_W-1];
      end
      SEL_SUB: begin
        re       = sext_part(ar) - sext_part(br);
        im       = sext_part(ai) - sext_part(bi);
        ovf_real = re[PART_W] ^ re[PART_W-1];
        ovf_imag = im[PART_W] ^ im[PART_W-1];
      end
      default: begin
        re       = sext_prod(p_rr) - sext_prod(p_ii);
        im       = sext_prod(p_ri) + sext_prod(p_ir);
        ovf_real = re[OPND_W] ^ re[OPND_W-1];
        ovf_imag = im[OPND_W] ^ im[OPND_W-1];
      end
    endcase
  end

  assign result = {re, im};

endmodule

// File: rtl/complex_alu_scheduler.sv
// Round-robin scheduler sharing one complex ALU between two requesters, one-deep response stage.
module complex_alu_scheduler
  import complex_alu_scheduler_pkg::*;
#(
  parameter int OVF_CNT_W = 8
) (
  input logic                    clk,
  input logic                    reset,
  complex_alu_scheduler_if.slave bus
);

  localparam logic [OVF_CNT_W-1:0] CNT_MAX = {OVF_CNT_W{1'b1}};

  state_e               state, next_state;
  logic                 last_grant;
  logic                 grant0, grant1;
  logic                 can_take;
  logic                 ready0, ready1;
  logic                 accept, accept_id;
  logic [OPND_W-1:0]    alu_a, alu_b;
  logic [1:0]           alu_sel;
  logic [RES_W-1:0]     alu_result;
  logic                 alu_ovf_real, alu_ovf_imag;
  logic [RES_W-1:0]     result_q;
  logic                 ovf_real_q, ovf_imag_q, id_q;
  logic [OVF_CNT_W-1:0] count_q;

  // Arbitration, ready generation and operand selection.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant0 = last_grant;
      grant1 = ~last_grant;
    end else if (bus.req0_valid) begin
      grant0 = 1'b1;
    end else if (bus.req1_valid) begin
      grant1 = 1'b1;
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
    can_take  = (state == ST_EMPTY) || bus.rsp_ready;
    ready0    = grant0 && can_take && !reset;
    ready1    = grant1 && can_take && !reset;
    accept_id = bus.req1_valid && ready1;
    accept    = (bus.req0_valid && ready0) || accept_id;
    if (accept_id) begin
      alu_a   = bus.req1_op_a;
      alu_b   = bus.req1_op_b;
      alu_sel = bus.req1_sel;
    end else begin
      alu_a   = bus.req0_op_a;
      alu_b   = bus.req0_op_b;
      alu_sel = bus.req0_sel;
    end
  end

  complex_alu_scheduler_alu alu (
    .op_a     (alu_a),
    .op_b     (alu_b),
    .sel      (alu_sel),
    .result   (alu_result),
    .ovf_real (alu_ovf_real),
    .ovf_imag (alu_ovf_imag)
  );

  // Response-stage next state.
  always_comb begin
    next_state = state;
    case (state)
      ST_EMPTY: begin
        if (accept) next_state = ST_FULL;
        else        next_state = ST_EMPTY;
      end
      ST_FULL: begin
        if (bus.rsp_ready && !accept) next_state = ST_EMPTY;
        else                          next_state = ST_FULL;
      end
      default: next_state = ST_EMPTY;
    endcase
  end

  // Response-stage state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_EMPTY;
    else       state <= next_state;
  end

  // Round-robin pointer; requester 0 wins the first tie after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_grant <= 1'b1;
    else if (accept) last_grant <= accept_id;
  end

  // Response payload captured on acceptance, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q   <= {RES_W{1'b0}};
      ovf_real_q <= 1'b0;
      ovf_imag_q <= 1'b0;
      id_q       <= 1'b0;
    end else if (accept) begin
      result_q   <= alu_result;
      ovf_real_q <= alu_ovf_real;
      ovf_imag_q <= alu_ovf_imag;
      id_q       <= accept_id;
    end
  end

  // Saturating overflow counter; clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= {OVF_CNT_W{1'b0}};
    end else if (bus.clr_count) begin
      count_q <= {OVF_CNT_W{1'b0}};
    end else if (accept && (alu_ovf_real || alu_ovf_imag) && (count_q != CNT_MAX)) begin
      count_q <= count_q + OVF_CNT_W'(1);
    end
  end

  assign bus.req0_ready   = ready0;
  assign bus.req1_ready   = ready1;
  assign bus.rsp_valid    = (state == ST_FULL);
  assign bus.rsp_result   = result_q;
  assign bus.rsp_ovf_real = ovf_real_q;
  assign bus.rsp_ovf_imag = ovf_imag_q;
  assign bus.rsp_id       = id_q;
  assign bus.ovf_count    = count_q;

endmodule

// File: tb/tb_complex_alu_scheduler.sv
// Directed bench for complex_alu_scheduler; uses a 3-bit counter so saturation is reachable.
module tb_complex_alu_scheduler;

  localparam int CW = 3;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  complex_alu_scheduler_if #(.OVF_CNT_W(CW)) bus ();

  complex_alu_scheduler #(.OVF_CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic [9:0] a, input logic [9:0] b, input logic [1:0] s);
    bus.req0_valid = v;
    bus.req0_op_a  = a;
    bus.req0_op_b  = b;
    bus.req0_sel   = s;
  endtask

  task automatic drive1(input logic v, input logic [9:0] a, input logic [9:0] b, input logic [1:0] s);
    bus.req1_valid = v;
    bus.req1_op_a  = a;
    bus.req1_op_b  = b;
    bus.req1_sel   = s;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive0(1'b1, 10'h062, 10'h021, 2'b00);
    drive1(1'b0, 10'h000, 10'h000, 2'b00);
    bus.rsp_ready = 1'b0;
    bus.clr_count = 1'b0;
    #1;
    chk("reset_ready0", 32'(bus.req0_ready), 32'h0);
    tick();
    tick();
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("reset_result", 32'(bus.rsp_result), 32'h0);
    chk("reset_id", 32'(bus.rsp_id), 32'h0);
    chk("reset_ovf", 32'({bus.rsp_ovf_real, bus.rsp_ovf_imag}), 32'h0);
    chk("reset_count", 32'(bus.ovf_count), 32'h0);
    reset = 1'b0;
    drive0(1'b0, 10'h000, 10'h000, 2'b00);
    tick();

    // add: (3+2i)+(1+1i)
    drive0(1'b1, 10'h062, 10'h021, 2'b00);
    bus.rsp_ready = 1'b1;
    #1;
    chk("add_ready0", 32'(bus.req0_ready), 32'h1);
    chk("add_ready1", 32'(bus.req1_ready), 32'h0);
    tick();
    drive0(1'b0, 10'h000, 10'h000, 2'b00);
    chk("add_valid", 32'(bus.rsp_valid), 32'h1);
    chk("add_result", 32'(bus.rsp_result), 32'h002003);
    chk("add_id", 32'(bus.rsp_id), 32'h0);
    chk("add_ovf", 32'({bus.rsp_ovf_real, bus.rsp_ovf_imag}), 32'h0);

    // multiply from requester 1, back-to-back with the held add response
    drive1(1'b1, 10'h021, 10'h021, 2'b10);
    #1;
    chk("mul_ready1", 32'(bus.req1_ready), 32'h1);
    tick();
    drive1(1'b0, 10'h000, 10'h000, 2'b00);
    chk("mul_valid", 32'(bus.rsp_valid), 32'h1);
    chk("mul_result", 32'(bus.rsp_result), 32'h000002);
    chk("mul_id", 32'(bus.rsp_id), 32'h1);
    chk("mul_count", 32'(bus.ovf_count), 32'h0);

    // real-part add overflow: 15+15
    drive0(1'b1, 10'h1E0, 10'h1E0, 2'b00);
    tick();
    drive0(1'b0, 10'h000, 10'h000, 2'b00);
    chk("ovf_result", 32'(bus.rsp_result), 32'h00F000);
    chk("ovf_real", 32'(bus.rsp_ovf_real), 32'h1);
    chk("ovf_imag", 32'(bus.rsp_ovf_imag), 32'h0);
    chk("ovf_count1", 32'(bus.ovf_count), 32'h1);

    // clear wins over a simultaneous overflow
    drive0(1'b1, 10'h1E0, 10'h1E0, 2'b00);
    bus.clr_count = 1'b1;
    tick();
    bus.clr_count = 1'b0;
    chk("clr_count", 32'(bus.ovf_count), 32'h0);
    chk("clr_ovf_real", 32'(bus.rsp_ovf_real), 32'h1);

    // nine more overflows saturate the 3-bit counter at 7
    for (int i = 0; i < 9; i++) tick();
    drive0(1'b0, 10'h000, 10'h000, 2'b00);
    chk("sat_count", 32'(bus.ovf_count), 32'h7);
    bus.clr_count = 1'b1;
    tick();
    bus.clr_count = 1'b0;
    chk("sat_clr", 32'(bus.ovf_count), 32'h0);
    chk("drain_valid", 32'(bus.rsp_valid), 32'h0);

    // subtract: (1+1i)-(3+2i) = -2-1i
    drive0(1'b1, 10'h021, 10'h062, 2'b01);
    tick();
    chk("sub_result", 32'(bus.rsp_result), 32'h3FF7FF);
    chk("sub_ovf", 32'({bus.rsp_ovf_real, bus.rsp_ovf_imag}), 32'h0);

    // subtract overflow: -16 - 1
    drive0(1'b1, 10'h200, 10'h020, 2'b01);
    tick();
    chk("subovf_result", 32'(bus.rsp_result), 32'h3F7800);
    chk("subovf_ovf", 32'({bus.rsp_ovf_real, bus.rsp_ovf_imag}), 32'h2);
    chk("subovf_count", 32'(bus.ovf_count), 32'h1);

    // multiply imag overflow via sel=11: (-16-16i)^2 -> imag 512
    drive0(1'b1, 10'h210, 10'h210, 2'b11);
    tick();
    chk("mulovf_result", 32'(bus.rsp_result), 32'h000200);
    chk("mulovf_ovf", 32'({bus.rsp_ovf_real, bus.rsp_ovf_imag}), 32'h1);
    chk("mulovf_count", 32'(bus.ovf_count), 32'h2);

    // multiply with negative real: 2 * -3, then hold it under backpressure
    drive0(1'b1, 10'h040, 10'h3A0, 2'b10);
    tick();
    drive0(1'b0, 10'h000, 10'h000, 2'b00);
    bus.rsp_ready = 1'b0;
    chk("mulneg_result", 32'(bus.rsp_result), 32'h3FD000);
    chk("mulneg_id", 32'(bus.rsp_id), 32'h0);
    tick();
    chk("hold_valid", 32'(bus.rsp_valid), 32'h1);

    // reset while FULL drops the response and the counter at once
    drive0(1'b1, 10'h062, 10'h021, 2'b00);
    reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.rsp_valid), 32'h0);
    chk("midrst_count", 32'(bus.ovf_count), 32'h0);
    chk("midrst_result", 32'(bus.rsp_result), 32'h0);
    chk("midrst_ready0", 32'(bus.req0_ready), 32'h0);
    tick();

    // fairness: both requesters valid, first tie goes to req0
    reset = 1'b0;
    drive1(1'b1, 10'h021, 10'h021, 2'b10);
    bus.rsp_ready = 1'b1;
    #1;
    chk("fair_ready0", 32'(bus.req0_ready), 32'h1);
    chk("fair_ready1", 32'(bus.req1_ready), 32'h0);
    tick();
    chk("fair0_id", 32'(bus.rsp_id), 32'h0);
    chk("fair0_result", 32'(bus.rsp_result), 32'h002003);
    chk("fair0_ready1", 32'(bus.req1_ready), 32'h1);
    tick();
    chk("fair1_id", 32'(bus.rsp_id), 32'h1);
    chk("fair1_result", 32'(bus.rsp_result), 32'h000002);
    tick();
    chk("fair2_id", 32'(bus.rsp_id), 32'h0);
    chk("fair2_valid", 32'(bus.rsp_valid), 32'h1);
    tick();
    chk("fair3_id", 32'(bus.rsp_id), 32'h1);
    chk("fair3_valid", 32'(bus.rsp_valid), 32'h1);

    // backpressure: three stalled cycles with the response held
    bus.rsp_ready = 1'b0;
    #1;
    chk("bp_ready0", 32'(bus.req0_ready), 32'h0);
    chk("bp_ready1", 32'(bus.req1_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("bp_id", 32'(bus.rsp_id), 32'h1);
      chk("bp_result", 32'(bus.rsp_result), 32'h000002);
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready0", 32'(bus.req0_ready), 32'h1);
    tick();
    chk("bp_next_id", 32'(bus.rsp_id), 32'h0);
    chk("bp_next_result", 32'(bus.rsp_result), 32'h002003);
    chk("bp_next_valid", 32'(bus.rsp_valid), 32'h1);
    drive0(1'b0, 10'h000, 10'h000, 2'b00);
    drive1(1'b0, 10'h000, 10'h000, 2'b00);
    tick();
    chk("final_empty", 32'(bus.rsp_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
